// File: rtl/id_stage_pipe.sv
// Pipelined RV32I instruction-decode stage.
// One-entry skid buffer in front of a registered ID/EX output slot, with
// load-use bubble insertion and flush.
module id_stage_pipe #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk_i_ID,
  input  logic              rst_i_ID,
  input  logic              flush_i_ID,
  input  logic              in_valid_i_ID,
  output logic              in_ready_o_ID,
  input  logic [31:0]       instr_i_ID,
  input  logic [XLEN-1:0]   pc_addr_i_ID,
  input  logic              ex_memrd_i_ID,
  input  logic [REG_AW-1:0] ex_rd_i_ID,
  output logic              out_valid_o_ID,
  input  logic              out_ready_i_ID,
  output logic [6:0]        OpCode_o_ID,
  output logic [2:0]        func3_o_ID,
  output logic [6:0]        func7_o_ID,
  output logic              RdEn_1_o_ID,
  output logic [REG_AW-1:0] Rd_Addr1_o_ID,
  output logic              RdEn_2_o_ID,
  output logic [REG_AW-1:0] Rd_Addr2_o_ID,
  output logic              WrEn_o_ID,
  output logic [REG_AW-1:0] Wr_Addr_o_ID,
  output logic [XLEN-1:0]   imm_o_ID,
  output logic [XLEN-1:0]   pc_addr_o_ID,
  output logic              illegal_o_ID
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic              skid_valid;
  logic [31:0]       skid_instr;
  logic [XLEN-1:0]   skid_pc;

  logic [31:0]       head_instr;
  logic [XLEN-1:0]   head_pc;
  logic              head_valid;

  logic              use_rs1, use_rs2, use_rd, known_op;
  logic [31:0]       imm32;
  logic [4:0]        rs1_f, rs2_f, rd_f;
  logic              reg_bad;
  logic [REG_AW-1:0] dec_rs1, dec_rs2, dec_rd;
  logic              dec_wen;
  logic [XLEN-1:0]   dec_imm;
  logic              dec_illegal;

  logic              hazard, advance, issue, accept;

  // While the skid is occupied it is the oldest instruction and takes priority.
  assign head_instr    = skid_valid ? skid_instr : instr_i_ID;
  assign head_pc       = skid_valid ? skid_pc    : pc_addr_i_ID;
  assign head_valid    = skid_valid || in_valid_i_ID;

  assign in_ready_o_ID = rst_i_ID && !skid_valid;
  assign advance       = !out_valid_o_ID || out_ready_i_ID;
  // IF is redirecting during a flush, so its handshake is ignored.
  assign accept        = in_valid_i_ID && in_ready_o_ID && !flush_i_ID;

  assign rs1_f = head_instr[19:15];
  assign rs2_f = head_instr[24:20];
  assign rd_f  = head_instr[11:7];

  // Format decode of the head instruction: operand usage and raw immediate.
  always_comb begin
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    use_rd   = 1'b0;
    known_op = 1'b1;
    imm32    = 32'd0;
    unique case (head_instr[6:0])
      OP_R: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        imm32   = {{20{head_instr[31]}}, head_instr[31:20]};
      end
      OP_STORE: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm32   = {{20{head_instr[31]}}, head_instr[31:25], head_instr[11:7]};
      end
      OP_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm32   = {{19{head_instr[31]}}, head_instr[31], head_instr[7],
                   head_instr[30:25], head_instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        use_rd  = 1'b1;
        imm32   = {head_instr[31:12], 12'd0};
      end
      OP_JAL: begin
        use_rd  = 1'b1;
        imm32   = {{11{head_instr[31]}}, head_instr[31], head_instr[19:12],
                   head_instr[20], head_instr[30:21], 1'b0};
      end
      default: known_op = 1'b0;
    endcase
  end

  // Register fields narrower than 5 bits (RV32E) must have their upper bits clear.
  always_comb begin
    reg_bad = (use_rs1 && ((rs1_f >> REG_AW) != 5'd0)) ||
              (use_rs2 && ((rs2_f >> REG_AW) != 5'd0)) ||
              (use_rd  && ((rd_f  >> REG_AW) != 5'd0));
    dec_rs1     = use_rs1 ? rs1_f[REG_AW-1:0] : '0;
    dec_rs2     = use_rs2 ? rs2_f[REG_AW-1:0] : '0;
    dec_rd      = use_rd  ? rd_f[REG_AW-1:0]  : '0;
    dec_wen     = use_rd && (rd_f != 5'd0);
    dec_illegal = !known_op || reg_bad;
    dec_imm     = {XLEN{imm32[31]}};
    dec_imm[31:0] = imm32;
  end

  // Load-use hazard: head reads a register the load in EX has not produced yet.
  always_comb begin
    hazard = ex_memrd_i_ID && (ex_rd_i_ID != '0) &&
             ((use_rs1 && (dec_rs1 == ex_rd_i_ID)) ||
              (use_rs2 && (dec_rs2 == ex_rd_i_ID)));
    issue  = advance && head_valid && !hazard;
  end

  // Skid buffer: catches an accepted instruction that cannot go straight to the output.
  always_ff @(posedge clk_i_ID) begin
    if (!rst_i_ID) begin
      skid_valid <= 1'b0;
      skid_instr <= 32'd0;
      skid_pc    <= '0;
    end else if (flush_i_ID) begin
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      if (issue) skid_valid <= 1'b0;
    end else if (accept && !issue) begin
      skid_valid <= 1'b1;
      skid_instr <= instr_i_ID;
      skid_pc    <= pc_addr_i_ID;
    end
  end

  // ID/EX output slot: loads on issue, bubbles on stall, holds under backpressure.
  always_ff @(posedge clk_i_ID) begin
    if (!rst_i_ID) begin
      out_valid_o_ID <= 1'b0;
      OpCode_o_ID    <= 7'd0;
      func3_o_ID     <= 3'd0;
      func7_o_ID     <= 7'd0;
      RdEn_1_o_ID    <= 1'b0;
      Rd_Addr1_o_ID  <= '0;
      RdEn_2_o_ID    <= 1'b0;
      Rd_Addr2_o_ID  <= '0;
      WrEn_o_ID      <= 1'b0;
      Wr_Addr_o_ID   <= '0;
      imm_o_ID       <= '0;
      pc_addr_o_ID   <= '0;
      illegal_o_ID   <= 1'b0;
    end else if (flush_i_ID) begin
      out_valid_o_ID <= 1'b0;
    end else if (advance) begin
      out_valid_o_ID <= issue;
      if (issue) begin
        OpCode_o_ID   <= head_instr[6:0];
        func3_o_ID    <= head_instr[14:12];
        func7_o_ID    <= head_instr[31:25];
        RdEn_1_o_ID   <= use_rs1;
        Rd_Addr1_o_ID <= dec_rs1;
        RdEn_2_o_ID   <= use_rs2;
        Rd_Addr2_o_ID <= dec_rs2;
        WrEn_o_ID     <= dec_wen;
        Wr_Addr_o_ID  <= dec_rd;
        imm_o_ID      <= dec_imm;
        pc_addr_o_ID  <= head_pc;
        illegal_o_ID  <= dec_illegal;
      end
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: directed test-plan steps followed by
// randomized traffic scored against an in-order queue model.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = 32'd0;
  logic [31:0] pc = 32'd0;
  logic        ex_memrd = 1'b0;
  logic [4:0]  ex_rd = 5'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic        rd_en1, rd_en2, wr_en;
  logic [4:0]  rd_addr1, rd_addr2, wr_addr;
  logic [31:0] imm, pc_out;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  typedef struct packed {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        r1en;
    logic [4:0]  r1;
    logic        r2en;
    logic [4:0]  r2;
    logic        wen;
    logic [4:0]  wa;
    logic [31:0] imm;
    logic        ill;
  } dec_t;

  ent_t q[$];

  id_stage_pipe #(.XLEN(32), .REG_AW(5)) dut (
    .clk_i_ID       (clk),
    .rst_i_ID       (rst),
    .flush_i_ID     (flush),
    .in_valid_i_ID  (in_valid),
    .in_ready_o_ID  (in_ready),
    .instr_i_ID     (instr),
    .pc_addr_i_ID   (pc),
    .ex_memrd_i_ID  (ex_memrd),
    .ex_rd_i_ID     (ex_rd),
    .out_valid_o_ID (out_valid),
    .out_ready_i_ID (out_ready),
    .OpCode_o_ID    (opcode),
    .func3_o_ID     (func3),
    .func7_o_ID     (func7),
    .RdEn_1_o_ID    (rd_en1),
    .Rd_Addr1_o_ID  (rd_addr1),
    .RdEn_2_o_ID    (rd_en2),
    .Rd_Addr2_o_ID  (rd_addr2),
    .WrEn_o_ID      (wr_en),
    .Wr_Addr_o_ID   (wr_addr),
    .imm_o_ID       (imm),
    .pc_addr_o_ID   (pc_out),
    .illegal_o_ID   (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decode, written directly from the RV32I format table.
  function automatic dec_t decode(input logic [31:0] i);
    dec_t d;
    bit u1, u2, ud, known;
    int s;
    d = '0;
    u1 = 0; u2 = 0; ud = 0; known = 1; s = 0;
    case (i[6:0])
      7'h33:               begin u1 = 1; u2 = 1; ud = 1; end
      7'h13, 7'h03, 7'h67: begin u1 = 1; ud = 1; s = $signed(i[31:20]); end
      7'h23:               begin u1 = 1; u2 = 1; s = $signed({i[31:25], i[11:7]}); end
      7'h63:               begin u1 = 1; u2 = 1;
                                 s = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0}); end
      7'h37, 7'h17:        begin ud = 1; s = int'(i[31:12]) * 4096; end
      7'h6F:               begin ud = 1;
                                 s = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0}); end
      default:             known = 0;
    endcase
    d.op   = i[6:0];
    d.f3   = i[14:12];
    d.f7   = i[31:25];
    d.r1en = u1;
    d.r1   = u1 ? i[19:15] : 5'd0;
    d.r2en = u2;
    d.r2   = u2 ? i[24:20] : 5'd0;
    d.wen  = ud && (i[11:7] != 5'd0);
    d.wa   = ud ? i[11:7] : 5'd0;
    d.imm  = s;
    d.ill  = !known;
    return d;
  endfunction

  function automatic logic [127:0] exp_fields(input ent_t e);
    dec_t d;
    d = decode(e.instr);
    return {d, e.pc};
  endfunction

  function automatic logic [127:0] dut_fields();
    return {opcode, func3, func7, rd_en1, rd_addr1, rd_en2, rd_addr2,
            wr_en, wr_addr, imm, illegal, pc_out};
  endfunction

  // One clock: check pre-edge state against the model, update the model with
  // the handshakes of this edge, then check out_valid after the edge.
  task automatic cycle();
    logic ov, adv, hz, exp_ov;
    dec_t d;
    #1;
    if (!rst) begin
      chk("in_ready_in_reset", in_ready, 1'b0);
      q.delete();
      @(posedge clk);
      @(negedge clk);
      chk("out_valid_after_reset", out_valid, 1'b0);
      chk("fields_after_reset", dut_fields(), 128'd0);
      return;
    end
    ov = out_valid;
    chk("in_ready", in_ready, (q.size() - (ov ? 1 : 0)) == 0);
    if (ov) begin
      if (q.size() == 0) chk("out_valid_spurious", ov, 1'b0);
      else chk("fields", dut_fields(), exp_fields(q[0]));
    end
    if (flush) begin
      q.delete();
      exp_ov = 1'b0;
    end else begin
      if (ov && out_ready && q.size() != 0) void'(q.pop_front());
      if (in_valid && in_ready) q.push_back('{instr: instr, pc: pc});
      adv = !ov || out_ready;
      if (!adv) exp_ov = 1'b1;
      else if (q.size() == 0) exp_ov = 1'b0;
      else begin
        d = decode(q[0].instr);
        hz = ex_memrd && (ex_rd != 5'd0) &&
             ((d.r1en && d.r1 == ex_rd) || (d.r2en && d.r2 == ex_rd));
        exp_ov = !hz;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("out_valid", out_valid, exp_ov);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] i;
    logic [6:0]  ops [10];
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};
    i = $urandom;
    i[6:0]   = ops[$urandom_range(0, 9)];
    i[19:15] = 5'($urandom_range(0, 3));
    i[24:20] = 5'($urandom_range(0, 3));
    return i;
  endfunction

  initial begin
    @(negedge clk);
    // Reset
    rst = 1'b0;
    in_valid = 1'b1; instr = 32'hFFF10093; pc = 32'h100;
    cycle();
    cycle();
    rst = 1'b1;

    // Decode of each test-plan instruction, back to back
    out_ready = 1'b1;
    in_valid = 1'b1; instr = 32'hFFF10093; pc = 32'h100;
    cycle();
    chk("addi_valid", out_valid, 1'b1);
    chk("addi_rs1", rd_addr1, 5'd2);
    chk("addi_rs2en", rd_en2, 1'b0);
    chk("addi_rd", wr_addr, 5'd1);
    chk("addi_imm", imm, 32'hFFFFFFFF);
    chk("addi_pc", pc_out, 32'h100);

    instr = 32'hFE000EE3; pc = 32'h104;
    cycle();
    chk("beq_imm", imm, 32'hFFFFFFFC);
    chk("beq_en", {rd_en1, rd_en2, wr_en}, 3'b110);

    instr = 32'h123452B7; pc = 32'h108;
    cycle();
    chk("lui_imm", imm, 32'h12345000);
    chk("lui_wr", {wr_en, wr_addr, rd_en1}, {1'b1, 5'd5, 1'b0});

    instr = 32'h00312423; pc = 32'h10C;
    cycle();
    chk("sw_imm", imm, 32'd8);
    chk("sw_regs", {rd_addr1, rd_addr2, wr_en}, {5'd2, 5'd3, 1'b0});

    instr = 32'h0000007F; pc = 32'h110;
    cycle();
    chk("illegal_flag", illegal, 1'b1);
    chk("illegal_en", {rd_en1, rd_en2, wr_en, imm}, 35'd0);

    // Load-use bubble
    instr = 32'hFFF10093; pc = 32'h200; ex_memrd = 1'b1; ex_rd = 5'd2;
    cycle();
    chk("loaduse_bubble", out_valid, 1'b0);
    chk("loaduse_held", in_ready, 1'b0);
    in_valid = 1'b0; ex_memrd = 1'b0;
    cycle();
    chk("loaduse_issue_pc", pc_out, 32'h200);
    cycle();

    // Backpressure: output + skid full, third held by IF
    out_ready = 1'b0;
    in_valid = 1'b1; instr = 32'h00500113; pc = 32'h300;
    cycle();
    instr = 32'h00A00193; pc = 32'h304;
    cycle();
    chk("bp_in_ready", in_ready, 1'b0);
    instr = 32'h00F00213; pc = 32'h308;
    cycle();
    cycle();
    chk("bp_hold_pc", pc_out, 32'h300);
    chk("bp_hold_imm", imm, 32'd5);
    out_ready = 1'b1;
    cycle();
    chk("bp_second_pc", pc_out, 32'h304);
    cycle();
    chk("bp_third_pc", pc_out, 32'h308);
    in_valid = 1'b0;
    cycle();

    // Flush with output and skid full
    out_ready = 1'b0;
    in_valid = 1'b1; instr = 32'h00100093; pc = 32'h400;
    cycle();
    pc = 32'h404;
    cycle();
    in_valid = 1'b0; flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_ready", in_ready, 1'b1);

    // Reset mid-stream
    out_ready = 1'b1;
    in_valid = 1'b1; instr = 32'h123452B7; pc = 32'h500;
    cycle();
    rst = 1'b0;
    cycle();
    chk("midreset_zero", {out_valid, dut_fields()}, 129'd0);
    rst = 1'b1; in_valid = 1'b0;
    cycle();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      instr     = rand_instr();
      pc        = $urandom & 32'hFFFF_FFFC;
      out_ready = ($urandom_range(0, 3) != 0);
      ex_memrd  = ($urandom_range(0, 2) == 0);
      ex_rd     = 5'($urandom_range(0, 3));
      flush     = ($urandom_range(0, 40) == 0);
      rst       = ($urandom_range(0, 300) != 0);
      cycle();
    end

    // Drain
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ex_memrd = 1'b0;
    for (int n = 0; n < 4; n++) cycle();
    chk("drain_empty", q.size() == 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised, pipelined successor to the combinational instruction-decode stage.
- Accepts fetched instruction/PC over a valid/ready handshake and decodes all RV32I formats (R/I/S/B/U/J) into per-format sign-extended immediates, operand-use enables and an illegal flag.
- Holds results in a registered ID/EX output slot backed by a one-entry skid buffer.
- Detects load-use hazards against the EX stage, inserts bubbles, and supports pipeline flush.

Parameters:
- XLEN, 32, datapath/PC/immediate width (32 or 64); immediates sign-extend to XLEN.
- REG_AW, 5, register address width (4 for RV32E: upper rs/rd bits must be 0, else illegal).

Ports:
- clk_i_ID  input  1  single clock; all state updates on rising edge.
- rst_i_ID  input  1  reset: synchronous, active-low.
- flush_i_ID  input  1  discard skid and output slot (branch/jump redirect).
- in_valid_i_ID  input  1  instr/PC valid from IF.
- in_ready_o_ID  output  1  stage can accept.
- instr_i_ID  input  32  instruction.
- pc_addr_i_ID  input  XLEN  instruction PC.
- ex_memrd_i_ID  input  1  instruction in EX is a load.
- ex_rd_i_ID  input  REG_AW  EX-stage destination register.
- out_valid_o_ID  output  1  output slot holds a decoded instruction.
- out_ready_i_ID  input  1  EX accepts the slot.
- OpCode_o_ID  output  7  opcode.
- func3_o_ID  output  3  func3.
- func7_o_ID  output  7  func7.
- RdEn_1_o_ID  output  1  rs1 used.
- Rd_Addr1_o_ID  output  REG_AW  rs1 (0 when unused).
- RdEn_2_o_ID  output  1  rs2 used.
- Rd_Addr2_o_ID  output  REG_AW  rs2 (0 when unused).
- WrEn_o_ID  output  1  rd written.
- Wr_Addr_o_ID  output  REG_AW  rd (0 when unused).
- imm_o_ID  output  XLEN  format-selected sign-extended immediate.
- pc_addr_o_ID  output  XLEN  PC of decoded instruction.
- illegal_o_ID  output  1  unknown opcode or out-of-range register.

Behaviour:
- Reset (rst_i_ID==0 at clock edge) clears skid_valid and out_valid; zeroes every registered output field, including illegal_o_ID.
- in_ready_o_ID = !skid_valid while not in reset; forced 0 during reset.
- head = skid entry if skid_valid, else the input (when in_valid_i_ID).
- advance = !out_valid || out_ready_i_ID.
- hazard = ex_memrd_i_ID && ex_rd_i_ID!=0 && ((head rs1 used && rs1==ex_rd) || (head rs2 used && rs2==ex_rd)).
- Each edge, priority order:
  - reset;
  - flush: out_valid=0, skid_valid=0, input not accepted in this cycle (IF is also redirecting);
  - advance && head valid && !hazard: output slot loads decode(head), out_valid=1. If head was the skid, it is consumed, and any input accepted this cycle enters the skid.
  - advance && (no head || hazard): out_valid=0 (bubble). An accepted input enters the skid.
  - !advance: output holds all fields stable. An accepted input enters the skid.
- Latency: accepted instruction visible on outputs 1 cycle later when unstalled. Throughput is 1/cycle.
- Decode by opcode:
  - R 0110011: rs1, rs2, rd.
  - I-ALU 0010011, LOAD 0000011, JALR 1100111: rs1, rd; imm = sext(instr[31:20]).
  - S 0100011: rs1, rs2; imm = sext({instr[31:25], instr[11:7]}).
  - B 1100011: rs1, rs2; imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - LUI 0110111, AUIPC 0010111: rd; imm = sext({instr[31:12], 12'b0}).
  - JAL 1101111: rd; imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - Other opcodes: illegal=1, all enables 0, addresses 0, imm 0.
- Shift-immediate: imm carries instr[31:20] unchanged; func7 output is always instr[31:25].
- WrEn_o_ID=0 when rd==0.
- Rd_Addr1_o_ID / Rd_Addr2_o_ID are never used to read the regfile while the matching enable is low.
- Output fields are don't-care when out_valid=0, but must not change while out_valid && !out_ready_i_ID.

Test Plan:
- Reset then addi x1,x2,-1 (0xFFF10093), PC 0x100 -> next cycle out_valid=1, Rd_Addr1=2, RdEn_2=0, Wr_Addr=1, imm=0xFFFFFFFF, pc_addr_o=0x100.
- beq x0,x0,-4 (0xFE000EE3) -> imm=0xFFFFFFFC, RdEn_1=RdEn_2=1, WrEn=0. lui x5,0x12345 (0x123452B7) -> imm=0x12345000, WrEn=1, Wr_Addr=5, RdEn_1=0.
- sw x3,8(x2) (0x00312423) -> imm=8, rs1=2, rs2=3, WrEn=0. Opcode 0x7F -> illegal=1, all enables 0.
- Load-use: ex_memrd=1, ex_rd=2 with addi x1,x2,-1 at head -> one bubble (out_valid=0), instruction held. Drop ex_memrd -> issues next cycle.
- Backpressure: out_ready=0, push three instructions -> first in output, second in skid, in_ready=0, third held by IF, outputs stable. Release -> all three emitted in order, one per cycle.
- Flush with output and skid full -> out_valid=0, in_ready=1 next cycle. Reset asserted mid-stream -> all outputs 0 at next edge.
